// File: rtl/key_pkg.sv
// key_pkg
// Shared keycode types and the report-membership helper used by the key
// event queue and its FIFO.
//   KEY_W      keycode width; keycode 0 marks an empty report slot
//   NUM_SLOTS  keycode slots carried by one report
package key_pkg;

  localparam int KEY_W     = 8;
  localparam int NUM_SLOTS = 6;

  typedef logic [KEY_W-1:0]           keycode_t;
  typedef logic [NUM_SLOTS*KEY_W-1:0] report_t;

  localparam keycode_t KEY_NONE = '0;

  // True when keycode k occupies any slot of the report.
  function automatic bit in_report(keycode_t k, report_t report);
    bit found;
    found = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (report[i*KEY_W +: KEY_W] == k) found = 1'b1;
    end
    return found;
  endfunction

endpackage

// File: rtl/key_event_fifo.sv
// key_event_fifo
// DEPTH-entry keycode FIFO accepting up to NUM_WR writes and one read per
// cycle. A read frees its entry before the same cycle's writes are placed;
// writes that do not fit are dropped, lowest write index kept first, and
// stored entries are never overwritten.
// Ports:
//   Clk, Reset  clock and synchronous active-high reset
//   wr_valid    one strobe per write lane, lane 0 written first
//   wr_data     lane i keycode = wr_data[i*KEY_W +: KEY_W]
//   rd_en       pop the head when non-empty
//   head        head keycode, KEY_NONE when empty
//   empty       no entries stored
//   count       occupancy
//   drop        at least one write was discarded this cycle
module key_event_fifo
  import key_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int NUM_WR = NUM_SLOTS + 1
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic [NUM_WR-1:0]          wr_valid,
  input  logic [NUM_WR*KEY_W-1:0]    wr_data,
  input  logic                       rd_en,
  output keycode_t                   head,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       drop
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  keycode_t         mem_q [DEPTH];
  keycode_t         mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  int               fill;

  // Pop first so its slot is free for this cycle's writes, then pack the
  // valid write lanes into consecutive entries while space remains.
  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    drop     = 1'b0;
    fill     = int'(count_q);
    if (rd_en && (count_q != '0)) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      fill     = fill - 1;
    end
    for (int i = 0; i < NUM_WR; i++) begin
      if (wr_valid[i]) begin
        if (fill < DEPTH) begin
          mem_d[wr_ptr_d] = wr_data[i*KEY_W +: KEY_W];
          wr_ptr_d        = wr_ptr_d + PTR_W'(1);
          fill            = fill + 1;
        end else begin
          drop = 1'b1;
        end
      end
    end
    count_d = CNT_W'(fill);
  end

  // Pointer and occupancy registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read while counted as valid.
  always_ff @(posedge Clk) begin
    mem_q <= mem_d;
  end

  assign empty = (count_q == '0);
  assign head  = empty ? KEY_NONE : mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/key_event_queue.sv
// key_event_queue
// Turns each newly pressed key of a multi-slot keyboard report into one
// press event and queues the events for game logic, drained over a
// valid/ready handshake.
// Optional build macro KEY_EVENT_QUEUE_REPEAT_EN adds typematic repeat of
// the most recently pressed key (REPEAT_DELAY / REPEAT_PERIOD parameters).
// Ports:
//   Clk, Reset  clock and synchronous active-high reset
//   keycodes    current report, slot i = keycodes[i*KEY_W +: KEY_W]
//   key_out     head event keycode, 0 when empty
//   key_valid   an event is waiting
//   key_ready   consumer pops the head when key_valid is high
//   count       queued events
//   overflow    sticky: an event was dropped since reset
module key_event_queue
  import key_pkg::*;
#(
  parameter int DEPTH = 8
`ifdef KEY_EVENT_QUEUE_REPEAT_EN
  ,
  parameter int REPEAT_DELAY  = 30,
  parameter int REPEAT_PERIOD = 6
`endif
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic [NUM_SLOTS*KEY_W-1:0] keycodes,
  output logic [KEY_W-1:0]           key_out,
  output logic                       key_valid,
  input  logic                       key_ready,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow
);

`ifdef KEY_EVENT_QUEUE_REPEAT_EN
  localparam int NUM_WR = NUM_SLOTS + 1;
`else
  localparam int NUM_WR = NUM_SLOTS;
`endif

  report_t                  prev_q, prev_d;
  logic                     overflow_q, overflow_d;
  logic [NUM_SLOTS-1:0]     new_press;
  logic [NUM_WR-1:0]        wr_valid;
  logic [NUM_WR*KEY_W-1:0]  wr_data;
  logic                     fifo_drop;
  logic                     fifo_empty;

  // A slot fires when it holds a real key that was absent from the whole
  // previous report; a key repeated in several slots fires only from its
  // lowest slot. Comparing against the whole previous report means that
  // shuffling held keys between slots never fires.
  always_comb begin
    new_press = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      new_press[i] = (keycodes[i*KEY_W +: KEY_W] != KEY_NONE) &&
                     !in_report(keycodes[i*KEY_W +: KEY_W], prev_q);
      for (int j = 0; j < i; j++) begin
        if (keycodes[j*KEY_W +: KEY_W] == keycodes[i*KEY_W +: KEY_W]) new_press[i] = 1'b0;
      end
    end
  end

  // Previous report and sticky overflow. Clearing prev on reset makes every
  // key still held after reset fire once.
  always_comb begin
    prev_d     = keycodes;
    overflow_d = overflow_q | fifo_drop;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      prev_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      prev_q     <= prev_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef KEY_EVENT_QUEUE_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W   = $clog2(REP_MAX + 1);

  keycode_t         trk_key_q, trk_key_d;
  logic             trk_active_q, trk_active_d;
  logic [REP_W-1:0] trk_cnt_q, trk_cnt_d;
  logic             trk_present;
  logic             rep_fire;
  keycode_t         newest;

  // The counter is loaded on a fresh press and counts down one per cycle;
  // the cycle it would reach zero the tracked key repeats and the counter
  // reloads with the period. Any fresh press retargets the tracker to the
  // highest-slot new key, even in a cycle where the old key repeats.
  always_comb begin
    newest = KEY_NONE;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (new_press[i]) newest = keycodes[i*KEY_W +: KEY_W];
    end
    trk_present  = in_report(trk_key_q, keycodes);
    rep_fire     = trk_active_q && trk_present && (trk_cnt_q == REP_W'(1));
    trk_key_d    = trk_key_q;
    trk_active_d = trk_active_q;
    trk_cnt_d    = trk_cnt_q;
    if (|new_press) begin
      trk_key_d    = newest;
      trk_active_d = 1'b1;
      trk_cnt_d    = REP_W'(REPEAT_DELAY);
    end else if (trk_active_q) begin
      if (!trk_present) begin
        trk_active_d = 1'b0;
      end else if (rep_fire) begin
        trk_cnt_d = REP_W'(REPEAT_PERIOD);
      end else begin
        trk_cnt_d = trk_cnt_q - REP_W'(1);
      end
    end
  end

  // Repeat tracker state.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      trk_key_q    <= KEY_NONE;
      trk_active_q <= 1'b0;
      trk_cnt_q    <= '0;
    end else begin
      trk_key_q    <= trk_key_d;
      trk_active_q <= trk_active_d;
      trk_cnt_q    <= trk_cnt_d;
    end
  end

  // The repeat lane sits above the slots so it lands after fresh presses.
  assign wr_valid = {rep_fire, new_press};
  assign wr_data  = {trk_key_q, keycodes};
`else
  assign wr_valid = new_press;
  assign wr_data  = keycodes;
`endif

  key_event_fifo #(
    .DEPTH (DEPTH),
    .NUM_WR(NUM_WR)
  ) u_fifo (
    .Clk     (Clk),
    .Reset   (Reset),
    .wr_valid(wr_valid),
    .wr_data (wr_data),
    .rd_en   (key_ready),
    .head    (key_out),
    .empty   (fifo_empty),
    .count   (count),
    .drop    (fifo_drop)
  );

  assign key_valid = !fifo_empty;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_key_event_queue.sv
// tb_key_event_queue
// Drives directed and random keyboard reports into key_event_queue and
// compares its outputs with an event-list model of press detection, the
// bounded queue and (when KEY_EVENT_QUEUE_REPEAT_EN is defined) typematic
// repeat timing.
module tb_key_event_queue;
  import key_pkg::*;

  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH + 1);
`ifdef KEY_EVENT_QUEUE_REPEAT_EN
  localparam int REPEAT_DELAY  = 30;
  localparam int REPEAT_PERIOD = 6;
`endif

  logic           Clk;
  logic           Reset;
  report_t        keycodes;
  keycode_t       key_out;
  logic           key_valid;
  logic           key_ready;
  logic [CW-1:0]  count;
  logic           overflow;

  int vectors;
  int miscompares;

  // Reference model: queued events, last report, sticky drop flag and the
  // most recently pressed key with the cycle it was pressed.
  keycode_t mq[$];
  keycode_t mprev [NUM_SLOTS];
  bit       movf;
  bit       mtrk_on;
  keycode_t mtrk_key;
  int       mtrk_t0;
  int       mcyc;

`ifdef KEY_EVENT_QUEUE_REPEAT_EN
  key_event_queue #(
    .DEPTH        (DEPTH),
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD)
  ) dut (
`else
  key_event_queue #(
    .DEPTH(DEPTH)
  ) dut (
`endif
    .Clk      (Clk),
    .Reset    (Reset),
    .keycodes (keycodes),
    .key_out  (key_out),
    .key_valid(key_valid),
    .key_ready(key_ready),
    .count    (count),
    .overflow (overflow)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic bit holds(input keycode_t r [NUM_SLOTS], input keycode_t k);
    foreach (r[i]) if (r[i] == k) return 1'b1;
    return 1'b0;
  endfunction

  function automatic report_t pack(input keycode_t s [NUM_SLOTS]);
    report_t r;
    for (int i = 0; i < NUM_SLOTS; i++) r[i*KEY_W +: KEY_W] = s[i];
    return r;
  endfunction

  // Apply one cycle of inputs, advance the model to the state after the
  // coming clock edge, then return at the following falling edge.
  task automatic drive(input report_t rpt, input logic rdy, input logic rst);
    keycode_t s [NUM_SLOTS];
    keycode_t wr[$];
    bit       fresh;
`ifdef KEY_EVENT_QUEUE_REPEAT_EN
    int       el;
    int       nfresh;
`endif
    keycodes  = rpt;
    key_ready = rdy;
    Reset     = rst;
    for (int i = 0; i < NUM_SLOTS; i++) s[i] = rpt[i*KEY_W +: KEY_W];
    if (rst) begin
      mq.delete();
      foreach (mprev[i]) mprev[i] = KEY_NONE;
      movf    = 1'b0;
      mtrk_on = 1'b0;
    end else begin
      if (rdy && mq.size() != 0) void'(mq.pop_front());
      for (int i = 0; i < NUM_SLOTS; i++) begin
        fresh = (s[i] != KEY_NONE) && !holds(mprev, s[i]);
        for (int j = 0; j < i; j++) if (s[j] == s[i]) fresh = 1'b0;
        if (fresh) wr.push_back(s[i]);
      end
`ifdef KEY_EVENT_QUEUE_REPEAT_EN
      nfresh = wr.size();
      if (mtrk_on && !holds(s, mtrk_key)) mtrk_on = 1'b0;
      if (mtrk_on) begin
        el = mcyc - mtrk_t0;
        if (el >= REPEAT_DELAY && ((el - REPEAT_DELAY) % REPEAT_PERIOD) == 0)
          wr.push_back(mtrk_key);
      end
      if (nfresh != 0) begin
        mtrk_key = wr[nfresh-1];
        mtrk_t0  = mcyc;
        mtrk_on  = 1'b1;
      end
`endif
      foreach (wr[i]) begin
        if (mq.size() < DEPTH) mq.push_back(wr[i]);
        else movf = 1'b1;
      end
      mprev = s;
    end
    mcyc++;
    @(negedge Clk);
  endtask

  task automatic test_reset();
    drive('0, 1'b0, 1'b1);
    vectors++;
    if (key_valid !== (mq.size() != 0)) begin
      miscompares++; $display("[TB] FAIL reset_valid: got %b expected %b", key_valid, mq.size() != 0);
    end
    vectors++;
    if (count !== CW'(mq.size())) begin
      miscompares++; $display("[TB] FAIL reset_count: got %0d expected %0d", count, mq.size());
    end
    vectors++;
    if (key_out !== KEY_NONE) begin
      miscompares++; $display("[TB] FAIL reset_key: got %0h expected 0", key_out);
    end
    vectors++;
    if (overflow !== movf) begin
      miscompares++; $display("[TB] FAIL reset_overflow: got %b expected %b", overflow, movf);
    end
    drive('0, 1'b0, 1'b0);
  endtask

  task automatic test_single_press();
    int vcycles;
    keycode_t exp_key;
    vcycles = 0;
    for (int c = 0; c < 10; c++) begin
      drive(report_t'(8'h04), 1'b1, 1'b0);
      exp_key = (mq.size() != 0) ? mq[0] : KEY_NONE;
      vectors++;
      if (key_valid !== (mq.size() != 0)) begin
        miscompares++; $display("[TB] FAIL single_valid c%0d: got %b expected %b", c, key_valid, mq.size() != 0);
      end
      vectors++;
      if (key_out !== exp_key) begin
        miscompares++; $display("[TB] FAIL single_key c%0d: got %0h expected %0h", c, key_out, exp_key);
      end
      if (key_valid === 1'b1) vcycles++;
    end
    vectors++;
    if (vcycles != 1) begin
      miscompares++; $display("[TB] FAIL single_valid_cycles: got %0d expected 1", vcycles);
    end
    drive('0, 1'b1, 1'b0);
    drive('0, 1'b1, 1'b0);
  endtask

  task automatic test_duplicates();
    report_t r;
    r = report_t'(24'h040504);
    drive(r, 1'b0, 1'b0);
    vectors++;
    if (count !== CW'(2)) begin
      miscompares++; $display("[TB] FAIL dup_count: got %0d expected 2", count);
    end
    vectors++;
    if (key_out !== 8'h04) begin
      miscompares++; $display("[TB] FAIL dup_first: got %0h expected 04", key_out);
    end
    drive(r, 1'b1, 1'b0);
    vectors++;
    if (key_out !== 8'h05) begin
      miscompares++; $display("[TB] FAIL dup_second: got %0h expected 05", key_out);
    end
    drive(r, 1'b1, 1'b0);
    vectors++;
    if (count !== CW'(mq.size())) begin
      miscompares++; $display("[TB] FAIL dup_drained: got %0d expected %0d", count, mq.size());
    end
    drive('0, 1'b1, 1'b0);
  endtask

  task automatic test_reorder();
    report_t seq [10];
    keycode_t exp_key;
    int ev;
    keycode_t ev_key;
    seq = '{report_t'(16'h0504), report_t'(16'h0504), report_t'(16'h0405), report_t'(16'h0405),
            report_t'(16'h0504), report_t'(8'h05), report_t'(16'h0504), report_t'(16'h0504),
            report_t'(0), report_t'(0)};
    ev = 0;
    ev_key = KEY_NONE;
    for (int c = 0; c < 10; c++) begin
      drive(seq[c], 1'b1, 1'b0);
      exp_key = (mq.size() != 0) ? mq[0] : KEY_NONE;
      vectors++;
      if (key_out !== exp_key) begin
        miscompares++; $display("[TB] FAIL reorder_key c%0d: got %0h expected %0h", c, key_out, exp_key);
      end
      vectors++;
      if (count !== CW'(mq.size())) begin
        miscompares++; $display("[TB] FAIL reorder_count c%0d: got %0d expected %0d", c, count, mq.size());
      end
      if (c >= 2 && key_valid === 1'b1) begin
        ev++;
        ev_key = key_out;
      end
    end
    vectors++;
    if (ev != 1 || ev_key !== 8'h04) begin
      miscompares++; $display("[TB] FAIL reorder_events: got %0d key %0h expected 1 key 04", ev, ev_key);
    end
  endtask

  task automatic test_overflow();
    keycode_t exp_key;
    drive('0, 1'b0, 1'b1);
    for (int k = 0; k < DEPTH + 2; k++) begin
      drive(report_t'(8'h10 + k), 1'b0, 1'b0);
      drive('0, 1'b0, 1'b0);
    end
    vectors++;
    if (count !== CW'(DEPTH)) begin
      miscompares++; $display("[TB] FAIL ovf_count: got %0d expected %0d", count, DEPTH);
    end
    vectors++;
    if (overflow !== 1'b1) begin
      miscompares++; $display("[TB] FAIL ovf_flag: got %b expected 1", overflow);
    end
    vectors++;
    if (key_out !== 8'h10) begin
      miscompares++; $display("[TB] FAIL ovf_head: got %0h expected 10", key_out);
    end
    drive(report_t'(8'h30), 1'b1, 1'b0);
    vectors++;
    if (count !== CW'(DEPTH)) begin
      miscompares++; $display("[TB] FAIL ovf_pop_push_count: got %0d expected %0d", count, DEPTH);
    end
    for (int i = 0; i < DEPTH; i++) begin
      exp_key = (i < DEPTH - 1) ? keycode_t'(32'h11 + i) : keycode_t'(8'h30);
      vectors++;
      if (key_out !== exp_key) begin
        miscompares++; $display("[TB] FAIL ovf_order i%0d: got %0h expected %0h", i, key_out, exp_key);
      end
      drive('0, 1'b1, 1'b0);
    end
    vectors++;
    if (count !== CW'(0) || overflow !== 1'b1) begin
      miscompares++; $display("[TB] FAIL ovf_drained: got count %0d ovf %b expected 0 1", count, overflow);
    end
  endtask

  task automatic test_reset_midstream();
    int ev;
    drive(report_t'(8'h01), 1'b0, 1'b0);
    drive(report_t'(8'h02), 1'b0, 1'b0);
    drive(report_t'(8'h03), 1'b0, 1'b0);
    vectors++;
    if (count !== CW'(3)) begin
      miscompares++; $display("[TB] FAIL mid_queued: got %0d expected 3", count);
    end
    drive(report_t'(8'h07), 1'b0, 1'b1);
    vectors++;
    if (count !== CW'(0) || key_valid !== 1'b0) begin
      miscompares++; $display("[TB] FAIL mid_flushed: got count %0d valid %b expected 0 0", count, key_valid);
    end
    vectors++;
    if (overflow !== 1'b0) begin
      miscompares++; $display("[TB] FAIL mid_overflow: got %b expected 0", overflow);
    end
    ev = 0;
    for (int c = 0; c < 5; c++) begin
      drive(report_t'(8'h07), 1'b1, 1'b0);
      if (key_valid === 1'b1) begin
        ev++;
        vectors++;
        if (key_out !== 8'h07) begin
          miscompares++; $display("[TB] FAIL mid_key c%0d: got %0h expected 07", c, key_out);
        end
      end
    end
    vectors++;
    if (ev != 1) begin
      miscompares++; $display("[TB] FAIL mid_events: got %0d expected 1", ev);
    end
    drive('0, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    keycode_t s [NUM_SLOTS];
    keycode_t exp_key;
    bit starve;
    logic rdy;
    logic rst;
    foreach (s[i]) s[i] = KEY_NONE;
    starve = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) s[$urandom_range(0, NUM_SLOTS-1)] = keycode_t'($urandom_range(0, 7));
      if ((c % 60) == 0) starve = 1'($urandom_range(0, 1));
      rdy = starve ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 199) == 0);
      drive(pack(s), rdy, rst);
      exp_key = (mq.size() != 0) ? mq[0] : KEY_NONE;
      vectors++;
      if (key_valid !== (mq.size() != 0)) begin
        miscompares++; $display("[TB] FAIL rand_valid c%0d: got %b expected %b", c, key_valid, mq.size() != 0);
      end
      vectors++;
      if (key_out !== exp_key) begin
        miscompares++; $display("[TB] FAIL rand_key c%0d: got %0h expected %0h", c, key_out, exp_key);
      end
      vectors++;
      if (count !== CW'(mq.size())) begin
        miscompares++; $display("[TB] FAIL rand_count c%0d: got %0d expected %0d", c, count, mq.size());
      end
      vectors++;
      if (overflow !== movf) begin
        miscompares++; $display("[TB] FAIL rand_overflow c%0d: got %b expected %b", c, overflow, movf);
      end
    end
  endtask

`ifdef KEY_EVENT_QUEUE_REPEAT_EN
  task automatic test_repeat();
    int ev_t[$];
    int l1;
    int l2;
    int n_exp;
    int t_exp;
    int ev;
    keycode_t exp_key;
    drive('0, 1'b0, 1'b1);
    l1 = REPEAT_DELAY + 3 * REPEAT_PERIOD + 2;
    for (int c = 0; c < l1; c++) begin
      drive(report_t'(8'h1A), 1'b1, 1'b0);
      exp_key = (mq.size() != 0) ? mq[0] : KEY_NONE;
      vectors++;
      if (key_out !== exp_key) begin
        miscompares++; $display("[TB] FAIL rep_key c%0d: got %0h expected %0h", c, key_out, exp_key);
      end
      if (key_valid === 1'b1) ev_t.push_back(c);
    end
    n_exp = 2 + (l1 - 1 - REPEAT_DELAY) / REPEAT_PERIOD;
    vectors++;
    if (ev_t.size() != n_exp) begin
      miscompares++; $display("[TB] FAIL rep_count: got %0d expected %0d", ev_t.size(), n_exp);
    end
    foreach (ev_t[i]) begin
      t_exp = (i == 0) ? 0 : REPEAT_DELAY + (i - 1) * REPEAT_PERIOD;
      vectors++;
      if (ev_t[i] != t_exp) begin
        miscompares++; $display("[TB] FAIL rep_time e%0d: got %0d expected %0d", i, ev_t[i], t_exp);
      end
    end
    l2 = REPEAT_DELAY + REPEAT_PERIOD + 2;
    ev = 0;
    for (int c = 0; c < l2; c++) begin
      drive(report_t'(16'h1B1A), 1'b1, 1'b0);
      if (key_valid === 1'b1) begin
        ev++;
        vectors++;
        if (key_out !== 8'h1B) begin
          miscompares++; $display("[TB] FAIL rep_switch c%0d: got %0h expected 1b", c, key_out);
        end
      end
    end
    vectors++;
    if (ev != 2 + (l2 - 1 - REPEAT_DELAY) / REPEAT_PERIOD) begin
      miscompares++; $display("[TB] FAIL rep_switch_count: got %0d expected %0d", ev,
                              2 + (l2 - 1 - REPEAT_DELAY) / REPEAT_PERIOD);
    end
    ev = 0;
    for (int c = 0; c < REPEAT_DELAY + 2 * REPEAT_PERIOD; c++) begin
      drive('0, 1'b1, 1'b0);
      if (key_valid === 1'b1) ev++;
    end
    vectors++;
    if (ev != 0) begin
      miscompares++; $display("[TB] FAIL rep_release: got %0d events expected 0", ev);
    end
  endtask
`endif

  initial begin
    vectors     = 0;
    miscompares = 0;
    mcyc        = 0;
    mtrk_on     = 1'b0;
    mtrk_key    = KEY_NONE;
    mtrk_t0     = 0;
    movf        = 1'b0;
    foreach (mprev[i]) mprev[i] = KEY_NONE;
    Reset     = 1'b1;
    keycodes  = '0;
    key_ready = 1'b0;
    @(negedge Clk);
    test_reset();
    test_single_press();
    test_duplicates();
    test_reorder();
    test_overflow();
    test_reset_midstream();
    test_random();
`ifdef KEY_EVENT_QUEUE_REPEAT_EN
    test_repeat();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
